// File: rtl/ram_burst_reader_if.sv
// Bundle between the burst read sequencer, the preloaded RAM and the downstream consumer.
// The sequencer connects through the slave modport.
interface ram_burst_reader_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 5
);
  logic                  start;
  logic [ADDR_WIDTH-1:0] base_addr;
  logic [ADDR_WIDTH:0]   len;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_q;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_vld;
  logic                  out_rdy;
  logic                  busy;
  logic                  done;

  modport master (
    output start, base_addr, len, ram_q, out_rdy,
    input  ram_addr, out_data, out_vld, busy, done
  );

  modport slave (
    input  start, base_addr, len, ram_q, out_rdy,
    output ram_addr, out_data, out_vld, busy, done
  );
endinterface

// File: rtl/ram_burst_reader.sv
// Walks a contiguous (wrapping) RAM address range and streams the words out through a
// 2-entry buffer that hides the RAM's one-cycle read latency under consumer backpressure.
module ram_burst_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  ram_burst_reader_if.slave   bus
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  localparam logic [ADDR_WIDTH:0] CNT_ZERO = {(ADDR_WIDTH+1){1'b0}};
  localparam logic [ADDR_WIDTH:0] CNT_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};

  state_t                state_r;
  state_t                state_s;
  logic [ADDR_WIDTH-1:0] base_r;
  logic [ADDR_WIDTH:0]   len_r;
  logic [ADDR_WIDTH:0]   issued_r;
  logic [ADDR_WIDTH:0]   accepted_r;
  logic                  inflight_r;
  logic [1:0]            count_r;
  logic                  head_r;
  logic                  tail_r;
  logic [DATA_WIDTH-1:0] buf_r [2];

  logic                  pop_s;
  logic                  push_s;
  logic                  issue_s;
  logic                  last_acc_s;
  logic [2:0]            credit_s;

  // Issue/accept decisions; credit counts buffered words plus the read still in flight.
  always_comb begin
    pop_s      = (count_r != 2'd0) && bus.out_rdy;
    push_s     = inflight_r;
    credit_s   = {1'b0, count_r} + {2'b00, inflight_r} - {2'b00, pop_s};
    issue_s    = (state_r == RUN) && (issued_r < len_r) && (credit_s < 3'd2);
    last_acc_s = (state_r == RUN) && pop_s && ((accepted_r + CNT_ONE) == len_r);
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.start) begin
          state_s = (bus.len == CNT_ZERO) ? FIN : RUN;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (last_acc_s) begin
          state_s = FIN;
        end else begin
          state_s = RUN;
        end
      end
      FIN:     state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Burst parameters, issue/accept counters and the in-flight flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_r     <= {ADDR_WIDTH{1'b0}};
      len_r      <= CNT_ZERO;
      issued_r   <= CNT_ZERO;
      accepted_r <= CNT_ZERO;
      inflight_r <= 1'b0;
    end else begin
      if ((state_r == IDLE) && bus.start) begin
        base_r     <= bus.base_addr;
        len_r      <= bus.len;
        issued_r   <= CNT_ZERO;
        accepted_r <= CNT_ZERO;
      end else begin
        if (issue_s) begin
          issued_r <= issued_r + CNT_ONE;
        end
        if (pop_s) begin
          accepted_r <= accepted_r + CNT_ONE;
        end
      end
      inflight_r <= issue_s;
    end
  end

  // Two-entry output FIFO; the RAM word lands in the tail the cycle after its read issues.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_r[0] <= {DATA_WIDTH{1'b0}};
      buf_r[1] <= {DATA_WIDTH{1'b0}};
      head_r   <= 1'b0;
      tail_r   <= 1'b0;
      count_r  <= 2'd0;
    end else begin
      if (push_s) begin
        buf_r[tail_r] <= bus.ram_q;
        tail_r        <= ~tail_r;
      end
      if (pop_s) begin
        head_r <= ~head_r;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + 2'd1;
        2'b01:   count_r <= count_r - 2'd1;
        default: count_r <= count_r;
      endcase
    end
  end

  assign bus.ram_addr = base_r + issued_r[ADDR_WIDTH-1:0];
  assign bus.out_vld  = (count_r != 2'd0);
  assign bus.out_data = buf_r[head_r];
  assign bus.busy     = (state_r != IDLE);
  assign bus.done     = (state_r == FIN);
endmodule

// File: tb/tb_ram_burst_reader.sv
// Directed bench for ram_burst_reader: a preloaded RAM model feeds the DUT, expected words
// are queued at start and a separate monitor checks every accepted word.
module tb_ram_burst_reader;
  localparam int DW    = 8;
  localparam int AW    = 5;
  localparam int DEPTH = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ram_burst_reader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  ram_burst_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] exp_q [$];
  int n_cmp = 0;
  int n_err = 0;
  int n_acc = 0;
  bit rnd_rdy = 1'b0;

  // Single-port RAM with registered address.
  always @(posedge clk) bus.ram_q <= mem[bus.ram_addr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Consumer ready: always 1 or 50% random.
  initial begin
    bus.out_rdy = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.out_rdy = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: compares each accepted word against the scoreboard and checks stall stability.
  initial begin
    logic          stall;
    logic [DW-1:0] held;
    stall = 1'b0;
    held  = '0;
    forever begin
      @(negedge clk);
      if (stall) begin
        check("stall_vld", 32'(bus.out_vld), 32'd1);
        check("stall_data", 32'(bus.out_data), 32'(held));
      end
      stall = bus.out_vld && !bus.out_rdy;
      held  = bus.out_data;
      if (bus.out_vld && bus.out_rdy) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL extra_word: got %0h, required no word (t=%0t)", bus.out_data, $time);
        end else begin
          check("out_data", 32'(bus.out_data), 32'(exp_q.pop_front()));
        end
        n_acc++;
      end
    end
  end

  // One burst: exp_done is the cycle (after the start edge) where done must be seen, 0 = any.
  task automatic run(input int b, input int l, input bit spurious, input int exp_done,
                     input bit chk_wrap);
    int done_cyc;
    logic [AW-1:0] addrs [$];
    @(posedge clk);
    #1;
    bus.start     = 1'b1;
    bus.base_addr = AW'(b);
    bus.len       = (AW+1)'(l);
    for (int i = 0; i < l; i++) exp_q.push_back(mem[(b + i) % DEPTH]);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    done_cyc  = 0;
    for (int c = 1; c <= 400 && done_cyc == 0; c++) begin
      @(negedge clk);
      if (c == 1) check("first_addr", 32'(bus.ram_addr), 32'(b % DEPTH));
      if (c <= 2) check("vld_early", 32'(bus.out_vld), 32'd0);
      if (c == 3) check("vld_latency", 32'(bus.out_vld), 32'(l != 0));
      if (chk_wrap && (addrs.size() == 0 || addrs[$] != bus.ram_addr)) addrs.push_back(bus.ram_addr);
      if (spurious && c == 2) begin
        bus.start     = 1'b1;
        bus.base_addr = AW'(10);
        bus.len       = (AW+1)'(3);
      end
      if (spurious && c == 3) bus.start = 1'b0;
      if (bus.done) begin
        done_cyc = c;
        check("busy_at_done", 32'(bus.busy), 32'd1);
      end
    end
    if (done_cyc == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL done_timeout: got no done, required done within 400 cycles");
    end else if (exp_done != 0) begin
      check("done_cycle", 32'(done_cyc), 32'(exp_done));
    end
    @(negedge clk);
    check("done_one_cycle", 32'(bus.done), 32'd0);
    check("busy_after", 32'(bus.busy), 32'd0);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    if (chk_wrap) begin
      check("wrap_addr_cnt", 32'(addrs.size() >= 4), 32'd1);
      for (int i = 0; i < 4 && i < addrs.size(); i++)
        check("wrap_addr", 32'(addrs[i]), 32'((b + i) % DEPTH));
    end
  endtask

  initial begin
    int acc0;
    for (int i = 0; i < DEPTH; i++) mem[i] = 8'hA0 + 8'(i);
    bus.start     = 1'b0;
    bus.base_addr = '0;
    bus.len       = '0;
    #2;
    check("rst_addr", 32'(bus.ram_addr), 32'd0);
    check("rst_vld", 32'(bus.out_vld), 32'd0);
    check("rst_data", 32'(bus.out_data), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run(3, 4, 1'b0, 7, 1'b0);       // basic burst A3..A6
    run(30, 4, 1'b0, 7, 1'b1);      // wrap 30,31,0,1
    rnd_rdy = 1'b1;
    run(0, 8, 1'b0, 0, 1'b0);       // backpressure A0..A7
    rnd_rdy = 1'b0;
    repeat (2) @(posedge clk);
    run(7, 0, 1'b0, 1, 1'b0);       // len=0
    run(5, 32, 1'b0, 35, 1'b0);     // full depth A5..BF,A0..A4
    run(3, 4, 1'b1, 7, 1'b0);       // start while busy ignored

    // Reset after two accepted words.
    @(posedge clk);
    #1;
    bus.start     = 1'b1;
    bus.base_addr = AW'(0);
    bus.len       = (AW+1)'(8);
    for (int i = 0; i < 8; i++) exp_q.push_back(mem[i]);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    acc0 = n_acc;
    for (int c = 0; c < 50 && n_acc < acc0 + 2; c++) @(posedge clk);
    #1;
    check("rst_wait_acc", 32'(n_acc - acc0), 32'd2);
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    check("mid_rst_addr", 32'(bus.ram_addr), 32'd0);
    check("mid_rst_vld", 32'(bus.out_vld), 32'd0);
    check("mid_rst_data", 32'(bus.out_data), 32'd0);
    check("mid_rst_busy", 32'(bus.busy), 32'd0);
    check("mid_rst_done", 32'(bus.done), 32'd0);
    repeat (3) begin
      @(negedge clk);
      check("rst_no_done", 32'(bus.done), 32'd0);
    end
    rst_n = 1'b1;
    run(0, 2, 1'b0, 5, 1'b0);       // fresh burst after reset

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/ram_burst_reader.md
Name: ram_burst_reader

Overview:
Read sequencer that sits directly downstream of the single-port preloaded RAM. On a start command it walks a contiguous address range, wrapping modulo RAM depth, and drives the RAM address. It absorbs the RAM's one-cycle registered-address read latency and streams the words out on a valid/ready interface, with a 2-entry output buffer so backpressure never drops or duplicates data. It is used to dump lookup tables and coefficient sets into downstream consumers.

Parameters:
DATA_WIDTH, 8, RAM word width and out_data width
ADDR_WIDTH, 5, RAM address width; RAM depth = 2**ADDR_WIDTH

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  reset, asynchronous, active-low
start  input  1  burst request, sampled only in IDLE
base_addr  input  ADDR_WIDTH  first word address, captured with start
len  input  ADDR_WIDTH+1  word count 0..2**ADDR_WIDTH, captured with start
ram_addr  output  ADDR_WIDTH  address to RAM
ram_q  input  DATA_WIDTH  RAM read data; valid the cycle after ram_addr is presented
out_data  output  DATA_WIDTH  head-of-buffer word
out_vld  output  1  out_data valid
out_rdy  input  1  consumer accepts when out_vld&out_rdy
busy  output  1  burst in progress
done  output  1  one-cycle pulse at burst completion

Behaviour:
- Single clock, one reset. Reset is asynchronous and active-low (rst_n); the clock is clk.
- Reset values: state=IDLE, ram_addr=0, out_vld=0, out_data=0, busy=0, done=0; buffer count, issue counter, accept counter and in-flight flag all 0.
- FSM states: IDLE, RUN, FIN.
  - IDLE: start=1 captures base_addr and len. len=0 goes to FIN; otherwise goes to RUN.
  - RUN: exits to FIN on the edge where the len-th word is accepted (out_vld&out_rdy).
  - FIN: done=1 for exactly one cycle, then IDLE.
- busy=1 whenever state is RUN or FIN. start is ignored outside IDLE, so a start during a burst has no effect.
- Address generation: ram_addr = base + issued, where issued is the issue counter, truncated to ADDR_WIDTH bits so the address wraps past 2**ADDR_WIDTH-1 to 0. ram_addr is combinational from the registers and holds its value when no read is issued.
- A read is issued in a RUN cycle when both hold:
  - issued < len
  - count + inflight - pop < 2, where pop = out_vld&out_rdy and inflight = a read was issued in the previous cycle.
- The in-flight flag registers the issue. In the following cycle ram_q is written into the buffer tail.
- Buffer: 2-entry FIFO. out_vld = (count != 0); out_data = head entry. Simultaneous push and pop is legal and leaves count unchanged. The credit rule guarantees no push when full; a push into a full buffer is a design error.
- Latency: start sampled at edge E0. First address presented in the cycle after E0. First word captured at E0+2; out_vld high from E0+3.
- Throughput: with out_rdy held at 1, one word per cycle after the first.
- The issue counter is ADDR_WIDTH+1 bits, so len=2**ADDR_WIDTH reads every location exactly once.
- Reset asserted mid-burst clears everything immediately (asynchronously). No done pulse. Data from a RAM read already in flight is discarded.
- out_data is undefined-but-stable while out_vld=0. It holds steady while out_vld=1 and out_rdy=0.

Test Plan:
1. RAM preloaded mem[i]=8'hA0+i; start with base=3, len=4, out_rdy=1. Required: out_vld from the 3rd cycle after start, out_data A3,A4,A5,A6 on consecutive cycles; done pulses one cycle after A6 is accepted; busy then falls.
2. Wrap: base=30, len=4. Required: ram_addr sequence 30,31,0,1; outputs BE,BF,A0,A1.
3. Backpressure: base=0, len=8, out_rdy pseudo-random at 50%. Required: output stream is exactly A0..A7 with no loss or duplicate; out_data stable while stalled; never more than 2 buffered plus 1 in flight.
4. Edge lengths: len=0 gives done one cycle after start with out_vld never high. len=32 with base=5 gives 32 words A5..BF then A0..A4.
5. Start while busy: assert start with base=10 during the scenario-1 burst. Required: ignored; output is still A3..A6 only.
6. Reset mid-burst: drop rst_n after 2 words are accepted. Required: all outputs return to reset values immediately and no done pulse. A fresh start with base=0, len=2 then gives A0,A1.
